// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer: state encoding, coin codes,
// price table and the default credit ceiling.
package vend_pkg;

  localparam int CREDIT_W           = 8;
  localparam int MAX_CREDIT_DEFAULT = 200;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // no credit held
    ST_COLLECT = 2'd1,  // credit > 0, accepting coins and selections
    ST_VEND    = 2'd2,  // waiting for the dispenser
    ST_CHANGE  = 2'd3   // paying out remaining credit coin by coin
  } state_t;

  typedef enum logic [1:0] {
    COIN_5   = 2'b00,
    COIN_10  = 2'b01,
    COIN_25  = 2'b10,
    COIN_BAD = 2'b11
  } coin_t;

  localparam logic [CREDIT_W-1:0] PRICE_ITEM0 = 8'd25;
  localparam logic [CREDIT_W-1:0] PRICE_ITEM1 = 8'd50;
  localparam logic [CREDIT_W-1:0] PRICE_ITEM2 = 8'd75;
  localparam logic [CREDIT_W-1:0] PRICE_ITEM3 = 8'd100;

  // Price in cents of a product index.
  function automatic logic [CREDIT_W-1:0] item_price(input logic [1:0] item);
    case (item)
      2'd0:    return PRICE_ITEM0;
      2'd1:    return PRICE_ITEM1;
      2'd2:    return PRICE_ITEM2;
      default: return PRICE_ITEM3;
    endcase
  endfunction

  // Value in cents of a coin code; the invalid code is worth nothing.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  return 8'd5;
      COIN_10: return 8'd10;
      COIN_25: return 8'd25;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_sel.sv
// Greedy change-coin picker: the largest coin that does not exceed the
// remaining credit. Credit is always a multiple of 5, so 5c is the floor.
module vend_change_sel
  import vend_pkg::*;
(
  input  logic [CREDIT_W-1:0] credit,
  output logic [1:0]          coin
);

  // Pick the biggest coin that fits in the remaining credit.
  always_comb begin
    if (credit >= 8'd25) begin
      coin = COIN_25;
    end else if (credit >= 8'd10) begin
      coin = COIN_10;
    end else begin
      coin = COIN_5;
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Vending machine sequencer: collects coins, arbitrates cancel/coin/select,
// drives the dispenser handshake with a timeout, and pays out change one
// coin at a time through the hopper handshake.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int MAX_CREDIT   = MAX_CREDIT_DEFAULT,
  parameter int DISP_TIMEOUT = 1000
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic                coin_valid,
  input  logic [1:0]          coin_val,
  input  logic                sel_valid,
  input  logic [1:0]          sel_item,
  input  logic                cancel,
  input  logic                disp_ack,
  input  logic                chg_ack,
  output logic                disp_req,
  output logic [1:0]          disp_item,
  output logic                chg_req,
  output logic [1:0]          chg_coin,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                insuf,
  output logic                fault
);

  // The timeout counter runs 0 .. DISP_TIMEOUT-1 while in VEND.
  localparam int TMO_W = (DISP_TIMEOUT > 1) ? $clog2(DISP_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(DISP_TIMEOUT - 1);
  localparam logic [CREDIT_W:0]   MAX_CREDIT_L = (CREDIT_W + 1)'(MAX_CREDIT);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [1:0]          item_q, item_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                gap_q, gap_d;       // one-cycle chg_req gap after each chg_ack
  logic                rej_q, rej_d;
  logic                insuf_q, insuf_d;
  logic                fault_q, fault_d;

  logic [1:0]          chg_coin_sel;
  logic [CREDIT_W-1:0] chg_val;
  logic [CREDIT_W-1:0] sel_price;
  logic [CREDIT_W-1:0] vend_price;
  logic [CREDIT_W:0]   coin_sum;           // one extra bit so the limit check cannot wrap
  logic                coin_ok;

  vend_change_sel u_change_sel (
    .credit (credit_q),
    .coin   (chg_coin_sel)
  );

  assign chg_val    = coin_value(chg_coin_sel);
  assign sel_price  = item_price(sel_item);
  assign vend_price = item_price(item_q);
  assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_value(coin_val)};
  assign coin_ok    = (coin_val != COIN_BAD) && (coin_sum <= MAX_CREDIT_L);

  // State and datapath registers; reset drops everything without refunding.
  // NOTE: every register here resets asynchronously so the outputs, which are
  // decoded from these registers, clear the moment RESET rises.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      item_q   <= '0;
      tmo_q    <= '0;
      gap_q    <= 1'b0;
      rej_q    <= 1'b0;
      insuf_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q  <= state_d;
      credit_q <= credit_d;
      item_q   <= item_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
      rej_q    <= rej_d;
      insuf_q  <= insuf_d;
      fault_q  <= fault_d;
    end
  end

  // Next-state and datapath update: arbitration, vend handshake, change payout.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch
    // is inferred; pulses and the gap flag default to 0 each cycle.
    state_d  = state_q;
    credit_d = credit_q;
    item_d   = item_q;
    tmo_d    = '0;
    gap_d    = 1'b0;
    rej_d    = 1'b0;
    insuf_d  = 1'b0;
    fault_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        // Priority cancel > coin > select, one event served per cycle.
        // Cancel only counts when there is credit to refund.
        if (cancel && (state_q == ST_COLLECT)) begin
          state_d = ST_CHANGE;
          rej_d   = coin_valid;
        end else if (coin_valid) begin
          if (coin_ok) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = ST_COLLECT;
          end else begin
            rej_d = 1'b1;
          end
        end else if (sel_valid) begin
          if (credit_q >= sel_price) begin
            state_d = ST_VEND;
            item_d  = sel_item;
          end else begin
            insuf_d = 1'b1;
          end
        end
      end

      ST_VEND: begin
        rej_d = coin_valid;
        if (disp_ack) begin
          // Credit is at least the price here, so the subtraction cannot wrap.
          credit_d = credit_q - vend_price;
          state_d  = (credit_q != vend_price) ? ST_CHANGE : ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          // Dispenser gave up: keep the whole credit and refund it.
          fault_d = 1'b1;
          state_d = ST_CHANGE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_CHANGE: begin
        rej_d = coin_valid;
        if (!gap_q && chg_ack) begin
          credit_d = credit_q - chg_val;
          gap_d    = 1'b1;
          if (credit_q == chg_val) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    disp_req    = (state_q == ST_VEND);
    disp_item   = item_q;
    chg_req     = (state_q == ST_CHANGE) && !gap_q;
    chg_coin    = (state_q == ST_CHANGE) ? chg_coin_sel : COIN_5;
    credit      = credit_q;
    coin_reject = rej_q;
    insuf       = insuf_q;
    fault       = fault_q;
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_vend_sequencer;

  localparam int MAXC = 200;
  localparam int TMO  = 40;

  logic       CLOCK_50 = 1'b0;
  logic       RESET;
  logic       coin_valid, sel_valid, cancel, disp_ack, chg_ack;
  logic [1:0] coin_val, sel_item;
  logic       disp_req, chg_req, coin_reject, insuf, fault;
  logic [1:0] disp_item, chg_coin;
  logic [7:0] credit;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: what the machine is doing, in plain terms.
  int m_credit;
  bit m_vending, m_refund, m_gap;
  int m_item, m_wait;
  bit m_rej, m_ins, m_flt;

  vend_sequencer #(.MAX_CREDIT(MAXC), .DISP_TIMEOUT(TMO)) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET       (RESET),
    .coin_valid  (coin_valid),
    .coin_val    (coin_val),
    .sel_valid   (sel_valid),
    .sel_item    (sel_item),
    .cancel      (cancel),
    .disp_ack    (disp_ack),
    .chg_ack     (chg_ack),
    .disp_req    (disp_req),
    .disp_item   (disp_item),
    .chg_req     (chg_req),
    .chg_coin    (chg_coin),
    .credit      (credit),
    .coin_reject (coin_reject),
    .insuf       (insuf),
    .fault       (fault)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic int price(input int item);
    return 25 * (item + 1);
  endfunction

  function automatic int cents(input int code);
    case (code)
      0: return 5;
      1: return 10;
      2: return 25;
      default: return 0;
    endcase
  endfunction

  function automatic int greedy(input int c);
    if (c >= 25) return 25;
    if (c >= 10) return 10;
    return 5;
  endfunction

  function automatic int code_of(input int c);
    if (c == 25) return 2;
    if (c == 10) return 1;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_vending = 0; m_refund = 0; m_gap = 0;
    m_item = 0; m_wait = 0; m_rej = 0; m_ins = 0; m_flt = 0;
  endtask

  // One clock of the machine's rules applied to the model.
  task automatic model_step(input bit cv, input int cval, input bit sv, input int si,
                            input bit can, input bit da, input bit ca);
    m_rej = 0; m_ins = 0; m_flt = 0;
    if (m_vending) begin
      m_rej = cv;
      if (da) begin
        m_credit  = m_credit - price(m_item);
        m_vending = 0;
        m_refund  = (m_credit > 0);
        m_gap     = 0;
      end else if (m_wait == TMO - 1) begin
        m_flt = 1; m_vending = 0; m_refund = 1; m_gap = 0;
      end else begin
        m_wait++;
      end
    end else if (m_refund) begin
      m_rej = cv;
      if (m_gap) begin
        m_gap = 0;
      end else if (ca) begin
        m_credit = m_credit - greedy(m_credit);
        m_gap = 1;
        if (m_credit == 0) m_refund = 0;
      end
    end else begin
      if (can && m_credit > 0) begin
        m_refund = 1; m_gap = 0; m_rej = cv;
      end else if (cv) begin
        if (cval != 3 && m_credit + cents(cval) <= MAXC) m_credit += cents(cval);
        else m_rej = 1;
      end else if (sv) begin
        if (m_credit >= price(si)) begin
          m_vending = 1; m_item = si; m_wait = 0;
        end else begin
          m_ins = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("credit", credit, m_credit);
    check("disp_req", disp_req, m_vending);
    if (m_vending) check("disp_item", disp_item, m_item);
    check("chg_req", chg_req, m_refund && !m_gap);
    if (m_refund && !m_gap) check("chg_coin", chg_coin, code_of(greedy(m_credit)));
    check("coin_reject", coin_reject, m_rej);
    check("insuf", insuf, m_ins);
    check("fault", fault, m_flt);
  endtask

  // Present inputs for one clock, advance the model, compare after the edge.
  task automatic tick(input bit cv, input int cval, input bit sv, input int si,
                      input bit can, input bit da, input bit ca);
    coin_valid = cv; coin_val = 2'(cval);
    sel_valid = sv; sel_item = 2'(si);
    cancel = can; disp_ack = da; chg_ack = ca;
    model_step(cv, cval, sv, si, can, da, ca);
    @(negedge CLOCK_50);
    coin_valid = 0; sel_valid = 0; cancel = 0; disp_ack = 0; chg_ack = 0;
    compare_all();
  endtask

  task automatic idle();          tick(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic coin(input int c); tick(1, c, 0, 0, 0, 0, 0); endtask
  task automatic sel(input int s);  tick(0, 0, 1, s, 0, 0, 0); endtask
  task automatic do_cancel();     tick(0, 0, 0, 0, 1, 0, 0); endtask
  task automatic dack();          tick(0, 0, 0, 0, 0, 1, 0); endtask
  task automatic cack();          tick(0, 0, 0, 0, 0, 0, 1); endtask

  task automatic do_reset();
    RESET = 1;
    model_reset();
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET = 0;
    compare_all();
  endtask

  // Keep acknowledging change until the refund completes (bounded).
  task automatic drain(input string tag);
    for (int i = 0; i < 100 && m_refund; i++) cack();
    check({tag, "_credit"}, credit, 0);
    check({tag, "_chg_req"}, chg_req, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit r_cv, r_sv, r_can, r_da, r_ca;
  int r_cval, r_si, ack_div;

  initial begin
    RESET = 1; coin_valid = 0; coin_val = 0; sel_valid = 0; sel_item = 0;
    cancel = 0; disp_ack = 0; chg_ack = 0;
    do_reset();
    check("rst_credit", credit, 0);
    check("rst_disp_req", disp_req, 0);

    // 25 + 25, item1: exact price, no change.
    coin(2); coin(2); sel(1);
    check("s1_disp_req", disp_req, 1);
    check("s1_disp_item", disp_item, 1);
    dack();
    check("s1_credit", credit, 0);
    check("s1_disp_drop", disp_req, 0);
    check("s1_no_chg", chg_req, 0);
    idle();

    // 85c, item2 (75c): 10c change.
    coin(2); coin(2); coin(2); coin(1); sel(2);
    check("s2_disp_item", disp_item, 2);
    dack();
    check("s2_credit", credit, 10);
    check("s2_chg_req", chg_req, 1);
    check("s2_chg_coin", chg_coin, 1);
    cack();
    check("s2_done_credit", credit, 0);
    check("s2_done_req", chg_req, 0);
    idle();

    // 30c cancel: 25 then 5 with a one-cycle gap.
    coin(2); coin(0); do_cancel();
    check("s3_chg_coin25", chg_coin, 2);
    cack();
    check("s3_gap", chg_req, 0);
    check("s3_credit5", credit, 5);
    idle();
    check("s3_req_again", chg_req, 1);
    check("s3_chg_coin5", chg_coin, 0);
    cack();
    check("s3_end_credit", credit, 0);
    idle();

    // 195c then a 10c coin overflows; then coin+cancel together.
    for (int i = 0; i < 7; i++) coin(2);
    coin(1); coin(1);
    check("s4_credit195", credit, 195);
    coin(1);
    check("s4_reject", coin_reject, 1);
    check("s4_credit_kept", credit, 195);
    tick(1, 2, 0, 0, 1, 0, 0);
    check("s4_cancel_reject", coin_reject, 1);
    check("s4_refund_start", chg_req, 1);
    drain("s4");

    // Invalid coin code.
    coin(3);
    check("s5_bad_code", coin_reject, 1);
    check("s5_credit", credit, 0);

    // Dispense timeout with 50c: fault, then refund 25 + 25.
    coin(2); coin(2); sel(0);
    for (int i = 0; i < TMO - 1; i++) idle();
    check("s6_still_vend", disp_req, 1);
    idle();
    check("s6_fault", fault, 1);
    check("s6_disp_drop", disp_req, 0);
    check("s6_credit50", credit, 50);
    check("s6_chg_coin", chg_coin, 2);
    cack();
    check("s6_credit25", credit, 25);
    idle();
    cack();
    check("s6_end", credit, 0);

    // Insufficient credit: 25c for item3.
    coin(2); sel(3);
    check("s7_insuf", insuf, 1);
    check("s7_credit", credit, 25);
    idle();

    // Async reset in the middle of a refund.
    coin(0); do_cancel();
    check("s8_in_change", chg_req, 1);
    #2 RESET = 1;
    #1;
    check("s8_async_chg_req", chg_req, 0);
    check("s8_async_credit", credit, 0);
    model_reset();
    @(negedge CLOCK_50);
    RESET = 0;
    compare_all();
    idle();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      ack_div = ((n / 250) % 2 == 1) ? 3 : 60;
      r_cv   = ($urandom_range(0, 3) == 0);
      r_cval = int'($urandom_range(0, 3));
      r_sv   = ($urandom_range(0, 4) == 0);
      r_si   = int'($urandom_range(0, 3));
      r_can  = ($urandom_range(0, 19) == 0);
      r_da   = ($urandom_range(0, ack_div) == 0);
      r_ca   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 799) == 0) do_reset();
      else tick(r_cv, r_cval, r_sv, r_si, r_can, r_da, r_ca);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
